// File: rtl/instr_fetch_stage.sv
// Instruction fetch stage: IDLE/RUN/HALT sequencer that walks a flat 8-entry
// program image and presents one instruction per cycle in an IF/ID register.
// Supports stall (hold), branch redirect (flush to a bubble) and halt after
// the last index.
// Optional build macro FETCH_WRAP_EN: the PC wraps to 0 after LAST_PC and the
// stage stays in RUN forever (HALT becomes unreachable).

module instr_fetch_stage #(
   parameter logic [7:0] NOP_INSTR = 8'h00,
   parameter logic [2:0] LAST_PC   = 3'd7
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [63:0] instrMemBits,
   input  logic        start,
   input  logic        stall,
   input  logic        branch_taken,
   input  logic [2:0]  branch_target,
   output logic [7:0]  instr_out,
   output logic [2:0]  pc_out,
   output logic        instr_valid,
   output logic        running,
   output logic        halted
);

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StRun  = 2'd1,
      StHalt = 2'd2
   } state_e;

   state_e     r_state;
   logic [2:0] r_pc;
   logic [7:0] r_instr;
   logic [2:0] r_pc_out;
   logic       r_valid;
   logic       r_running;
   logic       r_halted;

   logic [7:0] w_fetch_instr;
   logic [2:0] w_pc_inc;
   logic       w_last;

   // Instruction byte currently addressed by the PC; only consumed on fetch edges.
   assign w_fetch_instr = instrMemBits[{r_pc, 3'b000} +: 8];
   // 3-bit add wraps naturally modulo 8.
   assign w_pc_inc      = r_pc + 3'd1;
   assign w_last        = (r_pc == LAST_PC);

   // Sequencer: state, PC and the registered IF/ID outputs in one block.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= StIdle;
         r_pc      <= 3'd0;
         r_instr   <= NOP_INSTR;
         r_pc_out  <= 3'd0;
         r_valid   <= 1'b0;
         r_running <= 1'b0;
         r_halted  <= 1'b0;
      end else begin
         // Status flags are registered copies of the state decode, so they
         // trail the state register by one edge (halted rises the cycle
         // after the last instruction is presented).
         r_running <= (r_state == StRun);
         r_halted  <= (r_state == StHalt);

         case (r_state)
            StIdle: begin
               r_instr <= NOP_INSTR;
               r_valid <= 1'b0;
               if (start) begin
                  r_state <= StRun;
               end
            end

            StRun: begin
               if (branch_taken) begin
                  // Redirect wins over stall; flush the slot, keep pc_out.
                  r_pc    <= branch_target;
                  r_instr <= NOP_INSTR;
                  r_valid <= 1'b0;
               end else if (!stall) begin
                  r_instr  <= w_fetch_instr;
                  r_pc_out <= r_pc;
                  r_valid  <= 1'b1;
`ifdef FETCH_WRAP_EN
                  r_pc     <= w_last ? 3'd0 : w_pc_inc;
`else
                  r_pc     <= w_pc_inc;
                  if (w_last) begin
                     // The last fetch is still presented valid for this cycle.
                     r_state <= StHalt;
                  end
`endif
               end
            end

            StHalt: begin
               r_instr <= NOP_INSTR;
               r_valid <= 1'b0;
            end

            default: begin
               r_state <= StIdle;
               r_instr <= NOP_INSTR;
               r_valid <= 1'b0;
            end
         endcase
      end
   end

   assign instr_out   = r_instr;
   assign pc_out      = r_pc_out;
   assign instr_valid = r_valid;
   assign running     = r_running;
   assign halted      = r_halted;

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Self-checking bench for instr_fetch_stage: each cycle the expected IF/ID
// outputs are queued when stimulus is driven and popped after the edge.

module tb_instr_fetch_stage;

   logic        clk;
   logic        rst_n;
   logic [63:0] instrMemBits;
   logic        start;
   logic        stall;
   logic        branch_taken;
   logic [2:0]  branch_target;
   logic [7:0]  instr_out;
   logic [2:0]  pc_out;
   logic        instr_valid;
   logic        running;
   logic        halted;

   typedef struct packed {
      logic [7:0] instr;
      logic [2:0] pc;
      logic       valid;
      logic       run;
      logic       halt;
   } exp_t;

   exp_t sb_q[$];
   int   n_total = 0;
   int   n_bad   = 0;

   instr_fetch_stage dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .instrMemBits  (instrMemBits),
      .start         (start),
      .stall         (stall),
      .branch_taken  (branch_taken),
      .branch_target (branch_target),
      .instr_out     (instr_out),
      .pc_out        (pc_out),
      .instr_valid   (instr_valid),
      .running       (running),
      .halted        (halted)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "bench timeout");
   end

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", tag, got, exp);
      end
   endtask

   task automatic push_exp(input logic [7:0] ei, input logic [2:0] ep, input logic ev,
                           input logic er, input logic eh);
      exp_t e;
      e = '{instr: ei, pc: ep, valid: ev, run: er, halt: eh};
      sb_q.push_back(e);
   endtask

   task automatic compare_out(input string tag);
      exp_t e;
      check_val({tag, "_qdepth"}, sb_q.size(), 1);
      if (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         check_val({tag, "_instr"}, instr_out, e.instr);
         check_val({tag, "_pc"},    pc_out,    e.pc);
         check_val({tag, "_valid"}, instr_valid, e.valid);
         check_val({tag, "_run"},   running,   e.run);
         check_val({tag, "_halt"},  halted,    e.halt);
      end
   endtask

   // Drive one cycle of inputs, queue the expectation, sample #1 after the edge.
   task automatic cyc(input string tag, input logic st, input logic sl, input logic br,
                      input logic [2:0] tg, input logic [7:0] ei, input logic [2:0] ep,
                      input logic ev, input logic er, input logic eh);
      start         = st;
      stall         = sl;
      branch_taken  = br;
      branch_target = tg;
      push_exp(ei, ep, ev, er, eh);
      @(posedge clk);
      #1;
      compare_out(tag);
   endtask

   // Asynchronous reset pulse between edges; outputs must clear without a clock.
   task automatic reset_pulse(input string tag);
      start        = 1'b0;
      stall        = 1'b0;
      branch_taken = 1'b0;
      rst_n        = 1'b0;
      push_exp(8'h00, 3'd0, 1'b0, 1'b0, 1'b0);
      #1;
      compare_out(tag);
      #2;
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n         = 1'b0;
      start         = 1'b0;
      stall         = 1'b0;
      branch_taken  = 1'b0;
      branch_target = 3'd0;
      for (int i = 0; i < 8; i++) instrMemBits[8*i +: 8] = 8'h10 + 8'(i);

      #2;
      push_exp(8'h00, 3'd0, 1'b0, 1'b0, 1'b0);
      compare_out("por");
      rst_n = 1'b1;

      // Straight-line program from start.
      cyc("idle",  1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0);
      cyc("start", 1'b1, 1'b0, 1'b0, 3'd0, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0);
`ifdef FETCH_WRAP_EN
      for (int i = 0; i < 20; i++)
         cyc($sformatf("wrap%0d", i), 1'b0, 1'b0, 1'b0, 3'd0,
             8'h10 + 8'(i % 8), 3'(i % 8), 1'b1, 1'b1, 1'b0);
`else
      for (int i = 0; i < 8; i++)
         cyc($sformatf("seq%0d", i), 1'b0, 1'b0, 1'b0, 3'd0,
             8'h10 + 8'(i), 3'(i), 1'b1, 1'b1, 1'b0);
      // Bubble after the last fetch; start is ignored while halted.
      cyc("halt0", 1'b1, 1'b0, 1'b0, 3'd0, 8'h00, 3'd7, 1'b0, 1'b0, 1'b1);
      cyc("halt1", 1'b1, 1'b0, 1'b0, 3'd0, 8'h00, 3'd7, 1'b0, 1'b0, 1'b1);
      cyc("halt2", 1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 3'd7, 1'b0, 1'b0, 1'b1);
`endif
      reset_pulse("rst_a");

      // Branch, branch on the last index, stall, stall+branch priority.
      cyc("b_start", 1'b1, 1'b0, 1'b0, 3'd0, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0);
      cyc("b_f0",    1'b0, 1'b0, 1'b0, 3'd0, 8'h10, 3'd0, 1'b1, 1'b1, 1'b0);
      cyc("b_f1",    1'b0, 1'b0, 1'b0, 3'd0, 8'h11, 3'd1, 1'b1, 1'b1, 1'b0);
      cyc("br5",     1'b0, 1'b0, 1'b1, 3'd5, 8'h00, 3'd1, 1'b0, 1'b1, 1'b0);
      cyc("b_f5",    1'b0, 1'b0, 1'b0, 3'd0, 8'h15, 3'd5, 1'b1, 1'b1, 1'b0);
      cyc("b_f6",    1'b0, 1'b0, 1'b0, 3'd0, 8'h16, 3'd6, 1'b1, 1'b1, 1'b0);
      cyc("br_last", 1'b0, 1'b0, 1'b1, 3'd0, 8'h00, 3'd6, 1'b0, 1'b1, 1'b0);
      cyc("c_f0",    1'b0, 1'b0, 1'b0, 3'd0, 8'h10, 3'd0, 1'b1, 1'b1, 1'b0);
      cyc("c_f1",    1'b0, 1'b0, 1'b0, 3'd0, 8'h11, 3'd1, 1'b1, 1'b1, 1'b0);
      cyc("c_f2",    1'b0, 1'b0, 1'b0, 3'd0, 8'h12, 3'd2, 1'b1, 1'b1, 1'b0);
      // Image changes during a stall must not reach the held register.
      instrMemBits[23:16] = 8'hEE;
      instrMemBits[31:24] = 8'hEF;
      for (int i = 0; i < 3; i++)
         cyc($sformatf("stall%0d", i), 1'b0, 1'b1, 1'b0, 3'd0, 8'h12, 3'd2, 1'b1, 1'b1, 1'b0);
      instrMemBits[23:16] = 8'h12;
      instrMemBits[31:24] = 8'h13;
      cyc("c_f3",    1'b0, 1'b0, 1'b0, 3'd0, 8'h13, 3'd3, 1'b1, 1'b1, 1'b0);
      cyc("c_f4",    1'b0, 1'b0, 1'b0, 3'd0, 8'h14, 3'd4, 1'b1, 1'b1, 1'b0);
      cyc("stl_br",  1'b0, 1'b1, 1'b1, 3'd0, 8'h00, 3'd4, 1'b0, 1'b1, 1'b0);
      cyc("d_f0",    1'b0, 1'b0, 1'b0, 3'd0, 8'h10, 3'd0, 1'b1, 1'b1, 1'b0);
      cyc("d_f1",    1'b0, 1'b0, 1'b0, 3'd0, 8'h11, 3'd1, 1'b1, 1'b1, 1'b0);
      cyc("d_f2",    1'b0, 1'b0, 1'b0, 3'd0, 8'h12, 3'd2, 1'b1, 1'b1, 1'b0);
      cyc("d_f3",    1'b0, 1'b0, 1'b0, 3'd0, 8'h13, 3'd3, 1'b1, 1'b1, 1'b0);

      // Mid-run reset: clear immediately, wait in IDLE, then restart at index 0.
      reset_pulse("rst_mid");
      cyc("e_idle0", 1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0);
      cyc("e_idle1", 1'b0, 1'b1, 1'b1, 3'd6, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0);
      cyc("e_start", 1'b1, 1'b0, 1'b0, 3'd0, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0);
      cyc("e_f0",    1'b0, 1'b0, 1'b0, 3'd0, 8'h10, 3'd0, 1'b1, 1'b1, 1'b0);
      cyc("e_f1",    1'b1, 1'b0, 1'b0, 3'd0, 8'h11, 3'd1, 1'b1, 1'b1, 1'b0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule

// File: doc/instr_fetch_stage.md
INSTR_FETCH_STAGE -- requirements
Module: instr_fetch_stage

Interface
REQ-001 The block SHALL provide one clock and an asynchronous, active-low reset.
REQ-002 The block SHALL have parameter NOP_INSTR, default 8'h00: the instruction word inserted on flush or bubble.
REQ-003 The block SHALL have parameter LAST_PC, default 3'd7: the highest instruction index fetched.
REQ-004 The block SHALL have the following ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- instrMemBits  in  64  flat program image; instruction i = bits [8*i+7:8*i]
- start  in  1  one-cycle pulse; program load complete, begin fetching
- stall  in  1  hazard hold request
- branch_taken  in  1  redirect request
- branch_target  in  3  redirect index
- instr_out  out  8  IF/ID instruction register
- pc_out  out  3  index of instr_out
- instr_valid  out  1  instr_out holds a real fetched instruction
- running  out  1  FSM is in RUN
- halted  out  1  FSM is in HALT

Function
REQ-005 The FSM SHALL have exactly three states: IDLE, RUN and HALT.
REQ-006 IDLE SHALL go to RUN on the clock edge where start=1; start SHALL be ignored in RUN and HALT.
REQ-007 In RUN, with stall=0 and branch_taken=0, each edge SHALL:
- load instr_out with the instruction at pc;
- load pc_out with pc;
- set instr_valid=1;
- advance pc.
REQ-008 Fetch latency SHALL be one cycle: the first instruction (index 0) SHALL appear on the edge after the start edge.
REQ-009 In RUN, when stall=1 and branch_taken=0, pc, instr_out, pc_out and instr_valid SHALL all hold.
REQ-010 In RUN, when branch_taken=1, the block SHALL:
- set pc=branch_target;
- set instr_out=NOP_INSTR and instr_valid=0 (flush);
- leave pc_out holding its previous value.
REQ-011 branch_taken=1 SHALL take priority over stall=1 in the same cycle.
REQ-012 The PC SHALL be 3 bits and all PC arithmetic SHALL be modulo 8.
REQ-013 In IDLE and HALT, instr_out SHALL be NOP_INSTR, instr_valid SHALL be 0, and pc SHALL hold.
REQ-014 On leaving RUN for HALT, the instruction fetched on that edge SHALL still be presented with instr_valid=1 for one cycle, then SHALL become a bubble.
REQ-015 instrMemBits SHALL be sampled only at fetch edges; changes at other times SHALL have no effect.
REQ-016 running SHALL equal (state==RUN) and halted SHALL equal (state==HALT); both SHALL be registered.

Reset
REQ-017 When rst_n=0, the block SHALL immediately, without waiting for a clock edge, set:
- state=IDLE;
- pc=0 and pc_out=0;
- instr_out=NOP_INSTR;
- instr_valid=0, running=0, halted=0.
REQ-018 Reset asserted mid-RUN SHALL abort fetching; after release the block SHALL wait in IDLE for a new start.
REQ-019 HALT SHALL be left only by reset.

Configuration
REQ-020 With macro FETCH_WRAP_EN defined, fetching index LAST_PC SHALL wrap pc to 0 and the block SHALL remain in RUN indefinitely; HALT SHALL be unreachable and halted SHALL stay 0.
REQ-021 Without FETCH_WRAP_EN, the edge that fetches index LAST_PC SHALL move the FSM to HALT, unless branch_taken=1 on that edge, in which case the branch SHALL be taken and the FSM SHALL stay in RUN.

Verification
REQ-022 Load image bytes 0..7 = 8'h10..8'h17, pulse start -> instr_out sequence 10,11,...,17 on consecutive edges with pc_out 0..7; without FETCH_WRAP_EN halted=1 one cycle after pc_out=7.
REQ-023 Assert stall for 3 cycles while pc_out=2 -> instr_out holds 8'h12 for 4 cycles total, then 8'h13 follows.
REQ-024 Assert branch_taken with branch_target=5 while pc_out=1 -> one bubble (instr_valid=0, instr_out=8'h00), then 8'h15 with pc_out=5.
REQ-025 Assert stall and branch_taken (target 0) on the same edge at pc_out=4 -> a bubble, then 8'h10 with pc_out=0.
REQ-026 Pulse rst_n low mid-RUN at pc_out=3, then release -> outputs cleared immediately, block stays in IDLE until start, then the sequence restarts at 8'h10.
REQ-027 With FETCH_WRAP_EN defined, run 20 cycles -> pc_out sequence 0..7,0..7,0..3 and halted never asserts.
